// File: rtl/rtype_seq_ctrl_if.sv
// Instruction-memory fetch port shared by rtype_seq_ctrl and its memory.
interface rtype_seq_ctrl_if #(
    parameter int unsigned PC_WIDTH = 32
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_ready;
    logic [31:0]         imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/rtype_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the R-type integer core.
// Optional feature: define SEQ_INSTRET_EN to build the retired-instruction counter.
module rtype_seq_ctrl #(
    parameter int unsigned          PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  PC_RESET = '0,
    parameter int unsigned          PC_STEP  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    rtype_seq_ctrl_if.master        imem,
    input  logic                    halt_req,
    output logic [4:0]              rs1_addr,
    output logic [4:0]              rs2_addr,
    output logic [4:0]              rd_addr,
    output logic [2:0]              alu_control,
    output logic                    regwrite_en,
    output logic                    halted,
    output logic                    illegal,
    output logic [2:0]              state,
    output logic [31:0]             instret
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        WB     = 3'd3,
        HALT   = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] F7_BASE  = 7'h00;
    localparam logic [6:0] F7_ALT   = 7'h20;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         ir_q, ir_d;
    logic [2:0]          alu_q, alu_d;
    logic                illegal_q, illegal_d;
    logic                imem_req_q, regwrite_q, halted_q;
    logic                dec_ok;
    logic [2:0]          dec_alu;

    // Register addresses come straight from the latched word; stable DECODE..WB.
    assign rs1_addr = ir_q[19:15];
    assign rs2_addr = ir_q[24:20];
    assign rd_addr  = ir_q[11:7];

    assign imem.imem_req  = imem_req_q;
    assign imem.imem_addr = pc_q;
    assign alu_control    = alu_q;
    assign regwrite_en    = regwrite_q;
    assign halted         = halted_q;
    assign illegal        = illegal_q;
    assign state          = state_q;

    // R-type decode of the instruction register
    always_comb begin
        dec_ok  = 1'b0;
        dec_alu = alu_q;
        if (ir_q[6:0] == OP_RTYPE) begin
            case (ir_q[14:12])
                3'd0: begin
                    if (ir_q[31:25] == F7_BASE) begin
                        dec_ok  = 1'b1;
                        dec_alu = 3'b000;
                    end else if (ir_q[31:25] == F7_ALT) begin
                        dec_ok  = 1'b1;
                        dec_alu = 3'b001;
                    end
                end
                3'd7: begin dec_ok = (ir_q[31:25] == F7_BASE); dec_alu = 3'b010; end
                3'd6: begin dec_ok = (ir_q[31:25] == F7_BASE); dec_alu = 3'b011; end
                3'd4: begin dec_ok = (ir_q[31:25] == F7_BASE); dec_alu = 3'b100; end
                3'd2: begin dec_ok = (ir_q[31:25] == F7_BASE); dec_alu = 3'b101; end
                default: dec_ok = 1'b0;
            endcase
        end
    end

    // Next-state and datapath-control logic
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        alu_d     = alu_q;
        illegal_d = illegal_q;
        case (state_q)
            FETCH: begin
                if (imem.imem_ready) begin
                    ir_d    = imem.imem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (dec_ok) begin
                    alu_d   = dec_alu;
                    state_d = EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = TRAP;
                end
            end
            EXEC:    state_d = WB;
            WB: begin
                pc_d    = pc_q + PC_WIDTH'(PC_STEP);
                state_d = halt_req ? HALT : FETCH;
            end
            HALT:    if (!halt_req) state_d = FETCH;
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= PC_RESET;
            ir_q       <= '0;
            alu_q      <= '0;
            illegal_q  <= 1'b0;
            imem_req_q <= 1'b1;
            regwrite_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            alu_q      <= alu_d;
            illegal_q  <= illegal_d;
            imem_req_q <= (state_d == FETCH);
            regwrite_q <= (state_d == WB);
            halted_q   <= (state_d == HALT);
        end
    end

`ifdef SEQ_INSTRET_EN
    logic [31:0] instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (state_q == WB) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_rtype_seq_ctrl.sv
// Directed, table-driven bench for rtype_seq_ctrl, including halt, stall, trap, wrap and mid-instruction reset.
module tb_rtype_seq_ctrl;
    typedef struct {
        logic [31:0] word;
        logic [2:0]  alu;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        bit          legal;
    } vec_t;

    localparam int unsigned NV = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halt_req;
    logic        halt_req1;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr, rs1_addr1, rs2_addr1, rd_addr1;
    logic [2:0]  alu_control, alu_control1, state, state1;
    logic        regwrite_en, halted, illegal, regwrite_en1, halted1, illegal1;
    logic [31:0] instret, instret1;

    int          passed = 0;
    int          total = 0;
    int          cyc = 0;
    logic [31:0] pc_m;
    int          ret_m;
    logic [2:0]  alu_m;
    vec_t        vecs [NV];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rtype_seq_ctrl_if #(.PC_WIDTH(32)) imem0 ();
    rtype_seq_ctrl_if #(.PC_WIDTH(32)) imem1 ();

    rtype_seq_ctrl #(.PC_WIDTH(32), .PC_RESET(32'h0000_0000), .PC_STEP(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .imem(imem0), .halt_req(halt_req),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .alu_control(alu_control), .regwrite_en(regwrite_en), .halted(halted),
        .illegal(illegal), .state(state), .instret(instret)
    );

    rtype_seq_ctrl #(.PC_WIDTH(32), .PC_RESET(32'hFFFF_FFFC), .PC_STEP(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .imem(imem1), .halt_req(halt_req1),
        .rs1_addr(rs1_addr1), .rs2_addr(rs2_addr1), .rd_addr(rd_addr1),
        .alu_control(alu_control1), .regwrite_en(regwrite_en1), .halted(halted1),
        .illegal(illegal1), .state(state1), .instret(instret1)
    );

    function automatic logic [31:0] exp_instret(input int n);
`ifdef SEQ_INSTRET_EN
        return 32'(n);
`else
        return 32'd0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        halt_req = 1'b0;
        imem0.imem_ready = 1'b0;
        imem0.imem_rdata = 32'h0;
        step();
        step();
        rst_n = 1'b1;
        pc_m  = 32'h0;
        ret_m = 0;
        alu_m = 3'b000;
    endtask

    // Walk one instruction from FETCH; leaves the bench one cycle after WB (or parked in TRAP).
    task automatic run_instr(input vec_t v, input int stalls, input bit hold_halt);
        int c0;
        c0 = cyc;
        halt_req = 1'b0;
        chk("fetch_state", 32'(state), 32'd0);
        chk("fetch_req", 32'(imem0.imem_req), 32'd1);
        chk("fetch_addr", imem0.imem_addr, pc_m);
        imem0.imem_ready = 1'b0;
        imem0.imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < stalls; i++) begin
            step();
            chk("stall_state", 32'(state), 32'd0);
            chk("stall_req", 32'(imem0.imem_req), 32'd1);
            chk("stall_addr", imem0.imem_addr, pc_m);
        end
        imem0.imem_ready = 1'b1;
        imem0.imem_rdata = v.word;
        step();
        // DECODE: garbage with ready=1 must be ignored outside FETCH
        imem0.imem_rdata = 32'hFFFF_FFFF;
        chk("dec_state", 32'(state), 32'd1);
        chk("dec_rs1", 32'(rs1_addr), 32'(v.rs1));
        chk("dec_rs2", 32'(rs2_addr), 32'(v.rs2));
        chk("dec_rd", 32'(rd_addr), 32'(v.rd));
        chk("dec_we", 32'(regwrite_en), 32'd0);
        if (hold_halt) halt_req = 1'b1;
        step();
        if (!v.legal) begin
            chk("trap_state", 32'(state), 32'd5);
            chk("trap_illegal", 32'(illegal), 32'd1);
            chk("trap_alu", 32'(alu_control), 32'(alu_m));
            for (int i = 0; i < 3; i++) begin
                chk("trap_req", 32'(imem0.imem_req), 32'd0);
                chk("trap_we", 32'(regwrite_en), 32'd0);
                chk("trap_hold", 32'(state), 32'd5);
                chk("trap_pc", imem0.imem_addr, pc_m);
                step();
            end
            imem0.imem_ready = 1'b0;
            return;
        end
        chk("exec_state", 32'(state), 32'd2);
        chk("exec_alu", 32'(alu_control), 32'(v.alu));
        chk("exec_we", 32'(regwrite_en), 32'd0);
        alu_m = v.alu;
        step();
        imem0.imem_ready = 1'b0;
        chk("wb_state", 32'(state), 32'd3);
        chk("wb_we", 32'(regwrite_en), 32'd1);
        chk("wb_alu", 32'(alu_control), 32'(v.alu));
        chk("wb_rd", 32'(rd_addr), 32'(v.rd));
        chk("wb_latency", 32'(cyc - c0 + 1), 32'(4 + stalls));
        pc_m  = pc_m + 32'd4;
        ret_m = ret_m + 1;
        step();
        chk("post_we", 32'(regwrite_en), 32'd0);
        chk("post_instret", instret, exp_instret(ret_m));
        if (hold_halt) begin
            chk("halt_state", 32'(state), 32'd4);
            chk("halt_halted", 32'(halted), 32'd1);
            chk("halt_req_out", 32'(imem0.imem_req), 32'd0);
        end else begin
            chk("post_state", 32'(state), 32'd0);
            chk("post_addr", imem0.imem_addr, pc_m);
        end
    endtask

    initial begin
        vec_t add_v;
        vecs[0] = '{32'h0020_81B3, 3'b000, 5'd1, 5'd2, 5'd3, 1'b1};
        vecs[1] = '{32'h4020_81B3, 3'b001, 5'd1, 5'd2, 5'd3, 1'b1};
        vecs[2] = '{32'h0020_F1B3, 3'b010, 5'd1, 5'd2, 5'd3, 1'b1};
        vecs[3] = '{32'h0020_E1B3, 3'b011, 5'd1, 5'd2, 5'd3, 1'b1};
        vecs[4] = '{32'h0020_C1B3, 3'b100, 5'd1, 5'd2, 5'd3, 1'b1};
        vecs[5] = '{32'h0020_A1B3, 3'b101, 5'd1, 5'd2, 5'd3, 1'b1};
        vecs[6] = '{32'h01DF_4FB3, 3'b100, 5'd30, 5'd29, 5'd31, 1'b1};
        vecs[7] = '{32'h0000_0013, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0};
        vecs[8] = '{32'h0020_91B3, 3'b000, 5'd1, 5'd2, 5'd3, 1'b0};
        vecs[9] = '{32'h4020_F1B3, 3'b000, 5'd1, 5'd2, 5'd3, 1'b0};
        add_v = vecs[0];

        halt_req1 = 1'b0;
        imem1.imem_ready = 1'b1;
        imem1.imem_rdata = 32'h0020_81B3;
        do_reset();

        // Reset values, first cycle after release
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_req", 32'(imem0.imem_req), 32'd1);
        chk("rst_addr", imem0.imem_addr, 32'h0);
        chk("rst_alu", 32'(alu_control), 32'd0);
        chk("rst_we", 32'(regwrite_en), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_addr_wrapdut", imem1.imem_addr, 32'hFFFF_FFFC);

        // ADD at pc 0; the wrap DUT retires its first instruction alongside
        run_instr(add_v, 0, 1'b0);
        chk("wrap_addr", imem1.imem_addr, 32'h0);
        chk("wrap_instret", instret1, exp_instret(1));
        chk("wrap_state", 32'(state1), 32'd0);

        // Halt requested in WB of the instruction at pc 8
        run_instr(vecs[1], 0, 1'b0);
        run_instr(vecs[2], 0, 1'b1);
        imem0.imem_ready = 1'b1;
        step();
        chk("halt_hold_state", 32'(state), 32'd4);
        chk("halt_hold_req", 32'(imem0.imem_req), 32'd0);
        halt_req = 1'b0;
        imem0.imem_ready = 1'b0;
        step();
        chk("resume_state", 32'(state), 32'd0);
        chk("resume_addr", imem0.imem_addr, 32'h0000_000C);
        chk("resume_halted", 32'(halted), 32'd0);
        chk("resume_req", 32'(imem0.imem_req), 32'd1);

        // Three stall cycles in FETCH
        run_instr(vecs[3], 3, 1'b0);

        // Full table, resetting after each trap
        for (int i = 0; i < int'(NV); i++) begin
            run_instr(vecs[i], 0, 1'b0);
            if (!vecs[i].legal) do_reset();
        end

        // Reset asserted in EXEC: asynchronous, no write-back
        run_instr(add_v, 0, 1'b0);
        imem0.imem_ready = 1'b1;
        imem0.imem_rdata = add_v.word;
        step();
        imem0.imem_ready = 1'b0;
        step();
        chk("mid_exec_state", 32'(state), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_we", 32'(regwrite_en), 32'd0);
        chk("mid_rst_addr", imem0.imem_addr, 32'h0);
        chk("mid_rst_alu", 32'(alu_control), 32'd0);
        chk("mid_rst_instret", instret, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_hold_we", 32'(regwrite_en), 32'd0);
        end
        rst_n = 1'b1;
        pc_m = 32'h0;
        ret_m = 0;
        alu_m = 3'b000;
        step();
        chk("after_rst_we", 32'(regwrite_en), 32'd0);
        chk("after_rst_addr", imem0.imem_addr, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/rtype_seq_ctrl.md
# rtype_seq_ctrl

Multi-cycle sequencer for the R-type integer core. It fetches an instruction word from instruction memory with a request/ready handshake and decodes it into register addresses and a 3-bit ALU operation code. It then steps the shared ALU and register-file datapath through execute and write-back. It sits between the instruction memory port and the register file/ALU datapath, and it owns the program counter.

## Interface
Parameters:
- PC_WIDTH, 32, program counter and instruction address width
- PC_RESET, 0, PC value loaded on reset
- PC_STEP, 4, PC increment per retired instruction

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request; high throughout FETCH
- imem_addr  out  PC_WIDTH  fetch address; equals the PC
- imem_ready  in  1  instruction word valid this cycle
- imem_rdata  in  32  instruction word
- halt_req  in  1  request to pause before the next fetch
- rs1_addr, rs2_addr, rd_addr  out  5 each  register-file addresses from the latched instruction, bits [19:15], [24:20], [11:7]
- alu_control  out  3  ALU operation code
- regwrite_en  out  1  register-file write strobe, one cycle per retired instruction
- halted  out  1  high in HALT
- illegal  out  1  sticky illegal-instruction flag
- state  out  3  current FSM state, for debug
- instret  out  32  retired-instruction count; see Configuration

## Operation
- FSM encodings: FETCH=0, DECODE=1, EXEC=2, WB=3, HALT=4, TRAP=5.
- FETCH: imem_req=1 and imem_addr=pc. On a cycle with imem_ready=1, latch imem_rdata into the instruction register and go to DECODE. Otherwise stay in FETCH.
- DECODE: register alu_control from the latched word.
  - Opcode must be 0110011.
  - funct3=0 with funct7=0x00 -> 000 ADD.
  - funct3=0 with funct7=0x20 -> 001 SUB.
  - funct3=7 -> 010 AND; funct3=6 -> 011 OR; funct3=4 -> 100 XOR; funct3=2 -> 101 SLT. All four require funct7=0x00.
  - Any other combination: set illegal=1, leave alu_control unchanged, go to TRAP. Otherwise go to EXEC.
- EXEC: one cycle for the ALU result to settle. regwrite_en=0. Go to WB.
- WB:
  - regwrite_en=1 for exactly this cycle.
  - pc <= pc + PC_STEP, truncated to PC_WIDTH, so the PC wraps modulo 2^PC_WIDTH.
  - If halt_req=1 go to HALT, else go to FETCH.
- HALT: halted=1, imem_req=0. Return to FETCH on the first cycle halt_req=0.
- TRAP: terminal. imem_req=0, regwrite_en=0, illegal stays 1, pc is frozen. Only rst_n exits TRAP.
- halt_req is sampled only in WB and HALT. It has no effect mid-instruction.
- rs*/rd addresses are combinational from the instruction register and stay stable from DECODE through WB.

## Timing
- Reset values: state=FETCH, pc=PC_RESET, instruction register=0, alu_control=000, regwrite_en=0, illegal=0, halted=0, instret=0.
  - imem_req=1 in the first cycle after reset release.
- Assertion of rst_n=0 mid-instruction forces all reset values immediately (asynchronously). No partial write-back occurs; regwrite_en drops in the same cycle.
- Minimum latency per instruction is 4 cycles: FETCH (1 cycle with imem_ready=1), DECODE, EXEC, WB.
  - Each cycle of imem_ready=0 in FETCH adds one cycle.
  - Peak throughput is 1 instruction per 4 cycles.
- alu_control is valid from the first EXEC cycle through WB.
- imem_ready is ignored outside FETCH.
- imem_rdata is sampled only on the FETCH cycle where imem_ready=1.
- halt_req=1 in WB: the next cycle is HALT and regwrite_en=0. Release of halt_req: FETCH follows one cycle after the HALT cycle in which halt_req is sampled 0.

## Configuration
- SEQ_INSTRET_EN defined: instret is a 32-bit counter.
  - Increments on every WB cycle and wraps 0xFFFFFFFF -> 0.
  - Cleared by rst_n.
- SEQ_INSTRET_EN undefined: no counter is built and instret is tied to 0. The port stays present.

## Test plan
- Reset release, imem_ready=1, ADD word 0x002081B3 -> imem_addr=0, then alu_control=000, rd_addr=3, rs1_addr=1, rs2_addr=2, regwrite_en pulses in cycle 4, next imem_addr=4.
- Stream SUB 0x402081B3, AND, OR, XOR, SLT words with imem_ready=1 -> alu_control 001, 010, 011, 100, 101 respectively. regwrite_en pulses every 4th cycle.
- imem_ready held 0 for 3 cycles in FETCH -> imem_req stays 1, imem_addr stable, instruction retires in 7 cycles.
- Word 0x00000013 (I-type) or funct3=1 -> illegal=1, state=TRAP, no regwrite_en, imem_req=0 until rst_n.
- halt_req=1 during WB of the instruction at pc=8 -> HALT, halted=1, imem_req=0. Drop halt_req -> FETCH resumes at imem_addr=0xC.
- PC_RESET=0xFFFFFFFC, one retire -> imem_addr=0. With SEQ_INSTRET_EN, instret=1; without it, instret=0. Assert rst_n during EXEC -> regwrite_en never pulses and pc returns to PC_RESET.
